// File: rtl/stage_mem.sv
// Memory-access stage: issues single-beat loads/stores, checks alignment, formats
// load data and holds the MEM/WB pipeline register consumed by write-back.
module stage_mem #(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] rs2_d_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_ld_mem_i,
  input  logic        is_st_mem_i,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  output logic        wb_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_fault_o,
  output logic        e_st_fault_o
);

  typedef enum logic [0:0] { IDLE = 1'b0, BUS = 1'b1 } state_e;

  localparam logic [31:0] TIMEOUT_LAST = 32'(BUS_TIMEOUT) - 32'd1;

  state_e      state_r, state_next_s;
  logic        is_mem_s, legal_s, mis_s, accept_s, issue_s, timeout_s, done_s, live_s;
  logic [31:0] pc_h_r, instr_h_r, alu_h_r, cnt_r;
  logic [2:0]  funct3_h_r;
  logic        ld_h_r, st_h_r, flushed_r;

  function automatic logic [3:0] sel_of(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   sel_of = 4'b0001 << a;
      2'b01:   sel_of = 4'b0011 << a;
      default: sel_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] dat);
    logic [31:0] lanes;
    lanes = dat >> {a, 3'b000};
    case (f3)
      3'b000:  load_format = {{24{lanes[7]}}, lanes[7:0]};
      3'b001:  load_format = {{16{lanes[15]}}, lanes[15:0]};
      3'b010:  load_format = lanes;
      3'b100:  load_format = {24'd0, lanes[7:0]};
      3'b101:  load_format = {16'd0, lanes[15:0]};
      default: load_format = 32'd0;
    endcase
  endfunction

  // Decode of the incoming instruction and bus completion conditions
  always_comb begin
    is_mem_s = is_ld_mem_i || is_st_mem_i;
    legal_s  = (funct3_i != 3'b011) && (funct3_i != 3'b110) && (funct3_i != 3'b111);
    case (funct3_i[1:0])
      2'b01:   mis_s = alu_d_i[0];
      2'b10:   mis_s = (alu_d_i[1:0] != 2'b00);
      default: mis_s = 1'b0;
    endcase
    accept_s  = ex_valid_i && (state_r == IDLE) && !flush_i;
    issue_s   = accept_s && is_mem_s && legal_s && !mis_s;
    timeout_s = (BUS_TIMEOUT != 32'd0) && (cnt_r == TIMEOUT_LAST);
    done_s    = (state_r == BUS) && (dbus_ack_i || dbus_err_i || timeout_s);
    live_s    = !(flushed_r || flush_i);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = issue_s ? BUS : IDLE;
      BUS:     state_next_s = done_s ? IDLE : BUS;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake back to execute
  always_comb begin
    if (state_r == IDLE) begin
      ex_ready_o = 1'b1;
    end else begin
      ex_ready_o = 1'b0;
    end
  end

  // Bus request, held instruction context and MEM/WB register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbus_addr_o <= 32'd0; dbus_dat_o <= 32'd0; dbus_sel_o <= 4'd0;
      dbus_we_o <= 1'b0; dbus_cyc_o <= 1'b0;
      wb_valid_o <= 1'b0; pc_o <= 32'd0; instruction_o <= 32'd0; alu_d_o <= 32'd0;
      mem_d_o <= 32'd0; mem_addr_o <= 32'd0;
      e_ld_addr_mis_o <= 1'b0; e_st_addr_mis_o <= 1'b0;
      e_ld_fault_o <= 1'b0; e_st_fault_o <= 1'b0;
      pc_h_r <= 32'd0; instr_h_r <= 32'd0; alu_h_r <= 32'd0; cnt_r <= 32'd0;
      funct3_h_r <= 3'd0; ld_h_r <= 1'b0; st_h_r <= 1'b0; flushed_r <= 1'b0;
    end else begin
      // valid and flags are single-cycle pulses per instruction
      wb_valid_o <= 1'b0;
      e_ld_addr_mis_o <= 1'b0; e_st_addr_mis_o <= 1'b0;
      e_ld_fault_o <= 1'b0; e_st_fault_o <= 1'b0;
      if (state_r == IDLE) begin
        if (issue_s) begin
          dbus_addr_o <= {alu_d_i[31:2], 2'b00};
          dbus_dat_o  <= store_lanes(funct3_i[1:0], rs2_d_i);
          dbus_sel_o  <= sel_of(funct3_i[1:0], alu_d_i[1:0]);
          dbus_we_o   <= is_st_mem_i && !is_ld_mem_i;
          dbus_cyc_o  <= 1'b1;
          pc_h_r <= pc_i; instr_h_r <= instruction_i; alu_h_r <= alu_d_i;
          funct3_h_r <= funct3_i; ld_h_r <= is_ld_mem_i; st_h_r <= is_st_mem_i;
          flushed_r <= 1'b0; cnt_r <= 32'd0;
        end else if (ex_valid_i) begin
          wb_valid_o <= !flush_i;
          pc_o <= pc_i; instruction_o <= instruction_i; alu_d_o <= alu_d_i;
          mem_d_o <= 32'd0; mem_addr_o <= alu_d_i;
          e_ld_addr_mis_o <= accept_s && legal_s && mis_s && is_ld_mem_i;
          e_st_addr_mis_o <= accept_s && legal_s && mis_s && is_st_mem_i && !is_ld_mem_i;
        end
      end else begin
        cnt_r <= cnt_r + 32'd1;
        if (flush_i) begin
          flushed_r <= 1'b1;
        end
        // an issued access always completes; a flush only squashes its result
        if (done_s) begin
          dbus_cyc_o <= 1'b0;
          wb_valid_o <= live_s;
          pc_o <= pc_h_r; instruction_o <= instr_h_r; alu_d_o <= alu_h_r;
          mem_addr_o <= alu_h_r;
          mem_d_o <= (dbus_ack_i && ld_h_r) ? load_format(funct3_h_r, alu_h_r[1:0], dbus_dat_i)
                                            : 32'd0;
          e_ld_fault_o <= live_s && !dbus_ack_i && ld_h_r;
          e_st_fault_o <= live_s && !dbus_ack_i && st_h_r && !ld_h_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized bench for stage_mem: a transaction-level model predicts bus requests
// and MEM/WB contents; a compare process checks every write-back cycle.
module tb_stage_mem;
  localparam int unsigned TMO = 4;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        ex_valid_i = 1'b0, flush_i = 1'b0, ex_ready_o;
  logic [31:0] pc_i = 32'd0, instruction_i = 32'd0, alu_d_i = 32'd0, rs2_d_i = 32'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic        is_ld_mem_i = 1'b0, is_st_mem_i = 1'b0;
  logic [31:0] dbus_addr_o, dbus_dat_o, dbus_dat_i = 32'd0;
  logic [3:0]  dbus_sel_o;
  logic        dbus_we_o, dbus_cyc_o, dbus_ack_i = 1'b0, dbus_err_i = 1'b0;
  logic        wb_valid_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o;
  logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;

  stage_mem #(.BUS_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .flush_i(flush_i), .pc_i(pc_i), .instruction_i(instruction_i), .alu_d_i(alu_d_i),
    .rs2_d_i(rs2_d_i), .funct3_i(funct3_i), .is_ld_mem_i(is_ld_mem_i),
    .is_st_mem_i(is_st_mem_i), .dbus_addr_o(dbus_addr_o), .dbus_dat_o(dbus_dat_o),
    .dbus_sel_o(dbus_sel_o), .dbus_we_o(dbus_we_o), .dbus_cyc_o(dbus_cyc_o),
    .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
    .wb_valid_o(wb_valid_o), .pc_o(pc_o), .instruction_o(instruction_o),
    .alu_d_o(alu_d_o), .mem_d_o(mem_d_o), .mem_addr_o(mem_addr_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
    .e_ld_fault_o(e_ld_fault_o), .e_st_fault_o(e_st_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc, instr, alu, mem_d, mem_addr;
    logic [3:0]  flags;  // {ld_mis, st_mis, ld_fault, st_fault}
  } wb_t;

  wb_t         exp_q[$];
  wb_t         cmp_e;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          started = 1'b0;
  logic [3:0]  last_sel;
  logic [31:0] last_dat;
  logic        last_we, last_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    int off = int'(a[1:0]);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
    return s;
  endfunction

  function automatic logic [31:0] m_sdat(input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(f3);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] dat);
    int n = nbytes(f3);
    int off = int'(a[1:0]);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dat[8*(off + i) +: 8];
    if (!f3[2] && n < 4 && v[8*n - 1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Compare process: every write-back cycle against the model queue
  always @(negedge clk_i) begin
    if (started) begin
      if (wb_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("wb_pc", pc_o, cmp_e.pc);
          chk("wb_instr", instruction_o, cmp_e.instr);
          chk("wb_alu", alu_d_o, cmp_e.alu);
          chk("wb_mem_d", mem_d_o, cmp_e.mem_d);
          chk("wb_mem_addr", mem_addr_o, cmp_e.mem_addr);
          chk("wb_flags", 32'({e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o}),
              32'(cmp_e.flags));
        end
      end else begin
        chk("idle_flags", 32'({e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o}),
            32'd0);
      end
    end
  end

  // One instruction, called and returning at a negedge. resp: 0 ack, 1 err, 2 both, 3 none.
  // flush_at: -1 none, 0 flush with the accept, k flush in bus cycle k.
  task automatic do_instr(input logic [2:0] f3, input int kind, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int wait_n, input int resp, input int flush_at);
    logic ld, st, mem, legal, mis, bus, respond, done, ack_given, flushed;
    logic [31:0] pc, ins, edat;
    logic [3:0] esel;
    wb_t e;
    int n;
    ld = (kind == 1); st = (kind == 2); mem = ld || st;
    legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    n = nbytes(f3);
    mis = mem && legal && ((int'(addr[1:0]) % n) != 0);
    bus = mem && legal && !mis && (flush_at != 0);
    pc = $urandom; ins = $urandom;
    esel = m_sel(f3, addr); edat = m_sdat(f3, rs2);
    e.pc = pc; e.instr = ins; e.alu = addr; e.mem_addr = addr; e.mem_d = 32'd0;
    e.flags = {mis && ld, mis && st, 2'b00};
    ex_valid_i = 1'b1; pc_i = pc; instruction_i = ins; alu_d_i = addr; rs2_d_i = rs2;
    funct3_i = f3; is_ld_mem_i = ld; is_st_mem_i = st; flush_i = (flush_at == 0);
    if (!bus && flush_at != 0) exp_q.push_back(e);
    @(posedge clk_i); @(negedge clk_i);
    ex_valid_i = 1'b0; flush_i = 1'b0;
    pc_i = $urandom; instruction_i = $urandom; alu_d_i = $urandom; rs2_d_i = $urandom;
    funct3_i = 3'($urandom); is_ld_mem_i = 1'($urandom); is_st_mem_i = 1'($urandom);
    last_cyc = dbus_cyc_o; last_sel = dbus_sel_o; last_dat = dbus_dat_o; last_we = dbus_we_o;
    if (!bus) begin
      chk("nb_cyc", 32'(dbus_cyc_o), 32'd0);
      chk("nb_ready", 32'(ex_ready_o), 32'd1);
      chk("nb_wb_valid", 32'(wb_valid_o), 32'(flush_at != 0));
    end else begin
      flushed = 1'b0;
      for (int k = 1; k <= int'(TMO) + 8; k++) begin
        respond = (resp != 3) && (k == wait_n + 1);
        done = respond || (k == int'(TMO));
        chk("bus_cyc", 32'(dbus_cyc_o), 32'd1);
        chk("bus_addr", dbus_addr_o, {addr[31:2], 2'b00});
        chk("bus_sel", 32'(dbus_sel_o), 32'(esel));
        chk("bus_we", 32'(dbus_we_o), 32'(st));
        if (st) chk("bus_dat", dbus_dat_o, edat);
        chk("bus_ready", 32'(ex_ready_o), 32'd0);
        dbus_dat_i = respond ? rdata : $urandom;
        dbus_ack_i = respond && (resp == 0 || resp == 2);
        dbus_err_i = respond && (resp == 1 || resp == 2);
        flush_i = (k == flush_at);
        if (flush_at >= 1 && k >= flush_at) flushed = 1'b1;
        if (done) begin
          ack_given = dbus_ack_i;
          e.mem_d = (ack_given && ld) ? m_load(f3, addr, rdata) : 32'd0;
          e.flags = {2'b00, !ack_given && ld, !ack_given && st};
          if (!flushed) exp_q.push_back(e);
        end
        @(posedge clk_i); @(negedge clk_i);
        dbus_ack_i = 1'b0; dbus_err_i = 1'b0; flush_i = 1'b0; dbus_dat_i = $urandom;
        if (done) begin
          chk("done_cyc", 32'(dbus_cyc_o), 32'd0);
          chk("done_ready", 32'(ex_ready_o), 32'd1);
          chk("done_wb_valid", 32'(wb_valid_o), 32'(!flushed));
          break;
        end
      end
    end
  endtask

  initial begin
    int kind, r, fa, rsp;
    logic [2:0] f3;
    logic [31:0] a;
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", 32'(dbus_cyc_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_mem_d", mem_d_o, 32'd0);
    chk("rst_sel", 32'(dbus_sel_o), 32'd0);
    rst_i = 1'b0;
    started = 1'b1;

    chk("model_lb", m_load(3'b000, 32'h103, 32'h80FFFFFF), 32'hFFFFFF80);
    chk("model_sh", m_sdat(3'b001, 32'h1234ABCD), 32'hABCDABCD);

    do_instr(3'b010, 1, 32'h100, 32'd0, 32'hDEADBEEF, 3, 0, -1);
    chk("t1_mem_d", mem_d_o, 32'hDEADBEEF);
    chk("t1_sel", 32'(last_sel), 32'hF);
    chk("t1_we", 32'(last_we), 32'd0);
    do_instr(3'b000, 1, 32'h103, 32'd0, 32'h80FFFFFF, 0, 0, -1);
    chk("t2_lb", mem_d_o, 32'hFFFFFF80);
    chk("t2_sel", 32'(last_sel), 32'h8);
    do_instr(3'b100, 1, 32'h103, 32'd0, 32'h80FFFFFF, 0, 0, -1);
    chk("t2_lbu", mem_d_o, 32'h00000080);
    do_instr(3'b001, 2, 32'h202, 32'h1234ABCD, 32'd0, 1, 0, -1);
    chk("t3_dat", last_dat, 32'hABCDABCD);
    chk("t3_sel", 32'(last_sel), 32'hC);
    chk("t3_we", 32'(last_we), 32'd1);
    do_instr(3'b001, 1, 32'h101, 32'd0, 32'd0, 0, 0, -1);
    chk("t3_mis_cyc", 32'(last_cyc), 32'd0);
    chk("t3_mis_flag", 32'(e_ld_addr_mis_o), 32'd1);
    chk("t3_mis_addr", mem_addr_o, 32'h101);
    do_instr(3'b010, 1, 32'h300, 32'd0, 32'h55AA55AA, 2, 0, 1);
    chk("t4_wb_valid", 32'(wb_valid_o), 32'd0);
    do_instr(3'b010, 1, 32'h400, 32'd0, 32'd0, 0, 3, -1);
    chk("t5_fault", 32'(e_ld_fault_o), 32'd1);
    chk("t5_wb_valid", 32'(wb_valid_o), 32'd1);
    do_instr(3'b010, 2, 32'h404, 32'h01020304, 32'd0, 1, 1, -1);
    chk("st_fault", 32'(e_st_fault_o), 32'd1);
    do_instr(3'b011, 1, 32'h500, 32'd0, 32'd0, 0, 0, -1);
    chk("illegal_flags", 32'({e_ld_addr_mis_o, e_ld_fault_o}), 32'd0);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      rsp = (r <= 6) ? 0 : r - 6;
      r = $urandom_range(0, 9);
      fa = (r <= 2) ? r : -1;
      do_instr(f3, kind, a, $urandom, $urandom, $urandom_range(0, 5), rsp, fa);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    // reset in the middle of a bus cycle loses the instruction
    ex_valid_i = 1'b1; funct3_i = 3'b010; is_ld_mem_i = 1'b1; is_st_mem_i = 1'b0;
    alu_d_i = 32'h600; pc_i = 32'h80; flush_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    ex_valid_i = 1'b0;
    chk("t6_cyc_up", 32'(dbus_cyc_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    chk("t6_cyc", 32'(dbus_cyc_o), 32'd0);
    chk("t6_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("t6_ready", 32'(ex_ready_o), 32'd1);
    do_instr(3'b000, 0, 32'h12345678, 32'd0, 32'd0, 0, 0, -1);
    chk("t6_add_valid", 32'(wb_valid_o), 32'd1);
    chk("t6_add_alu", alu_d_o, 32'h12345678);

    repeat (3) @(negedge clk_i);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
